// File: rtl/lagd_ising_dispatcher.sv
// Job dispatcher for an array of Ising cores: queues annealing jobs, grants them
// round-robin to idle enabled cores, runs a per-core watchdog and returns completion records.
module lagd_ising_dispatcher #(
  parameter int unsigned NumCores     = 4,
  parameter int unsigned QueueDepth   = 8,
  parameter int unsigned JobIdWidth   = 8,
  parameter int unsigned CfgWidth     = 32,
  parameter int unsigned TimeoutWidth = 24,
  localparam int unsigned CoreIdxW    = (NumCores > 1) ? $clog2(NumCores) : 1,
  localparam int unsigned LvlW        = $clog2(QueueDepth) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [JobIdWidth-1:0]        job_id_i,
  input  logic [CfgWidth-1:0]          job_cfg_i,
  input  logic                         flush_i,
  input  logic [NumCores-1:0]          core_en_i,
  input  logic [TimeoutWidth-1:0]      timeout_cycles_i,
  output logic [NumCores-1:0]          core_start_o,
  output logic [NumCores*CfgWidth-1:0] core_cfg_o,
  input  logic [NumCores-1:0]          core_done_i,
  output logic                         done_valid_o,
  input  logic                         done_ready_i,
  output logic [JobIdWidth-1:0]        done_id_o,
  output logic [CoreIdxW-1:0]          done_core_o,
  output logic                         done_timeout_o,
  output logic [NumCores-1:0]          busy_o,
  output logic [LvlW-1:0]              queue_level_o,
  output logic                         irq_o
);

  // state | meaning
  // IDLE  | core free, may receive a job when enabled
  // RUN   | job executing, watchdog counting
  // PEND  | finished (done or timeout), waiting for completion handshake
  localparam int unsigned PtrW   = $clog2(QueueDepth);
  localparam logic [1:0]  StIdle = 2'd0;
  localparam logic [1:0]  StRun  = 2'd1;
  localparam logic [1:0]  StPend = 2'd2;

  logic [JobIdWidth-1:0]   fifo_id_q  [QueueDepth];
  logic [CfgWidth-1:0]     fifo_cfg_q [QueueDepth];
  logic [PtrW-1:0]         wr_q, rd_q;
  logic [LvlW-1:0]         lvl_q, lvl_d;
  logic                    full, push, pop;

  logic [1:0]              state_q [NumCores];
  logic [1:0]              state_d [NumCores];
  logic [TimeoutWidth-1:0] wd_q    [NumCores];
  logic [TimeoutWidth-1:0] wd_d    [NumCores];
  logic [JobIdWidth-1:0]   id_q    [NumCores];
  logic [CfgWidth-1:0]     cfg_q   [NumCores];
  logic [NumCores-1:0]     tmo_q, tmo_d, start_q, start_d, busy_q, busy_d;
  logic [NumCores-1:0]     cand, pend;

  logic [CoreIdxW-1:0]     rr_q, grant_idx, lo_idx, hi_idx, pend_idx, sel_q, sel;
  logic                    lo_vld, hi_vld, grant_vld;
  logic                    lock_q, done_vld, hs, irq_q, irq_d;

  // Job FIFO
  assign full        = (lvl_q == LvlW'(QueueDepth));
  assign job_ready_o = ~full;
  assign push        = job_valid_i & ~full & ~flush_i;
  assign pop         = grant_vld;

  always_comb begin
    if (flush_i) lvl_d = '0;
    else         lvl_d = lvl_q + LvlW'(push) - LvlW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      if (flush_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id_q[wr_q]  <= job_id_i;
      fifo_cfg_q[wr_q] <= job_cfg_i;
    end
  end

  always_comb begin
    for (int i = 0; i < NumCores; i++) begin
      cand[i] = (state_q[i] == StIdle) & core_en_i[i];
      pend[i] = (state_q[i] == StPend);
    end
  end

  // Round-robin: lowest candidate at/after rr_q, else lowest candidate overall
  always_comb begin
    lo_vld   = 1'b0;
    hi_vld   = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    pend_idx = '0;
    for (int i = NumCores - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_vld = 1'b1;
        lo_idx = CoreIdxW'(i);
        if (CoreIdxW'(i) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = CoreIdxW'(i);
        end
      end
      if (pend[i]) pend_idx = CoreIdxW'(i);
    end
    grant_idx = hi_vld ? hi_idx : lo_idx;
    grant_vld = lo_vld & (lvl_q != '0) & ~flush_i;
  end

  // Completion port; selection frozen once a record is presented
  assign done_vld       = |pend;
  assign sel            = lock_q ? sel_q : pend_idx;
  assign hs             = done_vld & done_ready_i;
  assign done_valid_o   = done_vld;
  assign done_id_o      = done_vld ? id_q[sel] : '0;
  assign done_core_o    = done_vld ? sel : '0;
  assign done_timeout_o = done_vld & tmo_q[sel];

  always_comb begin
    for (int i = 0; i < NumCores; i++) begin
      state_d[i] = state_q[i];
      wd_d[i]    = wd_q[i];
      tmo_d[i]   = tmo_q[i];
      start_d[i] = grant_vld & (grant_idx == CoreIdxW'(i));
      case (state_q[i])
        StIdle: begin
          if (start_d[i]) begin
            state_d[i] = StRun;
            wd_d[i]    = '0;
            tmo_d[i]   = 1'b0;
          end
        end
        StRun: begin
          if (core_done_i[i] && !start_q[i]) begin
            state_d[i] = StPend;
            tmo_d[i]   = 1'b0;
          end else if (timeout_cycles_i != '0 && wd_q[i] == timeout_cycles_i - 1'b1) begin
            state_d[i] = StPend;
            tmo_d[i]   = 1'b1;
          end else begin
            wd_d[i] = wd_q[i] + 1'b1;
          end
        end
        StPend: begin
          if (hs && sel == CoreIdxW'(i)) state_d[i] = StIdle;
        end
        default: state_d[i] = StIdle;
      endcase
      busy_d[i] = (state_d[i] != StIdle);
    end
    irq_d = hs & (lvl_d == '0) & ~|busy_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCores; i++) begin
        state_q[i] <= StIdle;
        wd_q[i]    <= '0;
        id_q[i]    <= '0;
        cfg_q[i]   <= '0;
      end
      tmo_q   <= '0;
      start_q <= '0;
      busy_q  <= '0;
      rr_q    <= '0;
      lock_q  <= 1'b0;
      sel_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NumCores; i++) begin
        state_q[i] <= state_d[i];
        wd_q[i]    <= wd_d[i];
        if (start_d[i]) begin
          id_q[i]  <= fifo_id_q[rd_q];
          cfg_q[i] <= fifo_cfg_q[rd_q];
        end
      end
      tmo_q   <= tmo_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      if (grant_vld) rr_q <= (grant_idx == CoreIdxW'(NumCores - 1)) ? '0 : grant_idx + 1'b1;
      if (hs)            lock_q <= 1'b0;
      else if (done_vld) lock_q <= 1'b1;
      if (done_vld && !lock_q) sel_q <= pend_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < NumCores; i++) core_cfg_o[i*CfgWidth +: CfgWidth] = cfg_q[i];
  end

  assign core_start_o  = start_q;
  assign busy_o        = busy_q;
  assign irq_o         = irq_q;
  assign queue_level_o = lvl_q;

endmodule

// File: tb/tb_lagd_ising_dispatcher.sv
// Randomized bench for lagd_ising_dispatcher against a queue-based job/core model,
// plus directed watchdog-latency and FIFO fill/flush checks.
module tb_lagd_ising_dispatcher;
  localparam int NC = 4;
  localparam int QD = 8;
  localparam int IW = 8;
  localparam int CW = 32;
  localparam int TW = 24;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              job_valid_i;
  logic              job_ready_o;
  logic [IW-1:0]     job_id_i;
  logic [CW-1:0]     job_cfg_i;
  logic              flush_i;
  logic [NC-1:0]     core_en_i;
  logic [TW-1:0]     timeout_cycles_i;
  logic [NC-1:0]     core_start_o;
  logic [NC*CW-1:0]  core_cfg_o;
  logic [NC-1:0]     core_done_i;
  logic              done_valid_o;
  logic              done_ready_i;
  logic [IW-1:0]     done_id_o;
  logic [1:0]        done_core_o;
  logic              done_timeout_o;
  logic [NC-1:0]     busy_o;
  logic [3:0]        queue_level_o;
  logic              irq_o;

  always #5 clk_i = ~clk_i;

  lagd_ising_dispatcher #(
    .NumCores(NC), .QueueDepth(QD), .JobIdWidth(IW), .CfgWidth(CW), .TimeoutWidth(TW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_id_i(job_id_i), .job_cfg_i(job_cfg_i), .flush_i(flush_i),
    .core_en_i(core_en_i), .timeout_cycles_i(timeout_cycles_i),
    .core_start_o(core_start_o), .core_cfg_o(core_cfg_o), .core_done_i(core_done_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .done_id_o(done_id_o),
    .done_core_o(done_core_o), .done_timeout_o(done_timeout_o),
    .busy_o(busy_o), .queue_level_o(queue_level_o), .irq_o(irq_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: pending jobs as queues, each core as a small record
  logic [IW-1:0] mq_id[$];
  logic [CW-1:0] mq_cfg[$];
  int            m_st[NC];   // 0 idle, 1 running, 2 finished awaiting handshake
  int            m_age[NC];
  logic [IW-1:0] m_id[NC];
  logic [CW-1:0] m_cfg[NC];
  bit            m_tmo[NC];
  bit            m_start[NC];
  int            m_rr;
  bit            m_lock;
  int            m_sel;
  bit            m_irq;

  int cyc;
  int t_start, t_dv;
  bit t_flag;

  function automatic void model_reset();
    mq_id.delete();
    mq_cfg.delete();
    for (int i = 0; i < NC; i++) begin
      m_st[i] = 0; m_age[i] = 0; m_id[i] = '0; m_cfg[i] = '0;
      m_tmo[i] = 0; m_start[i] = 0;
    end
    m_rr = 0; m_lock = 0; m_sel = 0; m_irq = 0;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic step();
    bit dv, hs, push, all_idle;
    int sel, g, tmo;
    logic [NC-1:0] sv, bv;
    #1;
    if (!rst_ni) model_reset();
    dv = 0; sel = 0;
    for (int i = 0; i < NC; i++) if (m_st[i] == 2 && !dv) begin dv = 1; sel = i; end
    if (m_lock) sel = m_sel;
    for (int i = 0; i < NC; i++) begin
      sv[i] = m_start[i];
      bv[i] = (m_st[i] != 0);
    end
    chk("job_ready", job_ready_o, mq_id.size() < QD);
    chk("queue_level", queue_level_o, mq_id.size());
    chk("core_start", core_start_o, sv);
    chk("busy", busy_o, bv);
    for (int i = 0; i < NC; i++) chk("core_cfg", core_cfg_o[i*CW +: CW], m_cfg[i]);
    chk("done_valid", done_valid_o, dv);
    chk("done_id", done_id_o, dv ? m_id[sel] : '0);
    chk("done_core", done_core_o, dv ? sel : 0);
    chk("done_timeout", done_timeout_o, dv ? m_tmo[sel] : 1'b0);
    chk("irq", irq_o, m_irq);
    if (core_start_o[0] && t_start < 0) t_start = cyc;
    if (done_valid_o && t_dv < 0) begin t_dv = cyc; t_flag = done_timeout_o; end

    if (rst_ni) begin
      hs   = dv && done_ready_i;
      push = job_valid_i && (mq_id.size() < QD) && !flush_i;
      tmo  = int'(timeout_cycles_i);
      g    = -1;
      if (mq_id.size() > 0 && !flush_i) begin
        for (int k = 0; k < NC; k++) begin
          int c;
          c = (m_rr + k) % NC;
          if (g < 0 && m_st[c] == 0 && core_en_i[c]) g = c;
        end
      end
      for (int i = 0; i < NC; i++) begin
        case (m_st[i])
          0: if (g == i) begin
               m_st[i] = 1; m_age[i] = 0; m_tmo[i] = 0;
               m_id[i] = mq_id[0]; m_cfg[i] = mq_cfg[0];
             end
          1: if (core_done_i[i] && !m_start[i]) begin
               m_st[i] = 2; m_tmo[i] = 0;
             end else if (tmo != 0 && m_age[i] == tmo - 1) begin
               m_st[i] = 2; m_tmo[i] = 1;
             end else m_age[i]++;
          default: if (hs && sel == i) m_st[i] = 0;
        endcase
      end
      for (int i = 0; i < NC; i++) m_start[i] = (g == i);
      if (flush_i) begin
        mq_id.delete();
        mq_cfg.delete();
      end else begin
        if (g >= 0) begin void'(mq_id.pop_front()); void'(mq_cfg.pop_front()); end
        if (push) begin mq_id.push_back(job_id_i); mq_cfg.push_back(job_cfg_i); end
      end
      if (g >= 0) m_rr = (g + 1) % NC;
      if (hs) m_lock = 0;
      else if (dv) begin m_lock = 1; m_sel = sel; end
      all_idle = 1;
      for (int i = 0; i < NC; i++) if (m_st[i] != 0) all_idle = 0;
      m_irq = hs && (mq_id.size() == 0) && all_idle;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; job_valid_i = 1'b0; job_id_i = '0; job_cfg_i = '0; flush_i = 1'b0;
    core_en_i = '0; timeout_cycles_i = '0; core_done_i = '0; done_ready_i = 1'b1;
    model_reset();
    cyc = 0; t_start = -1; t_dv = -1; t_flag = 0;
    @(negedge clk_i);
    repeat (2) step();
    rst_ni = 1'b1;

    // Core 0 never reports done: record must appear 10 cycles after start, flagged timeout
    core_en_i = 4'b0001; timeout_cycles_i = 24'd10;
    job_valid_i = 1'b1; job_id_i = 8'h11; job_cfg_i = 32'hA5A5_0011;
    step();
    job_valid_i = 1'b0;
    repeat (16) step();
    chk("wd_latency", 64'(t_dv - t_start), 64'd10);
    chk("wd_flag", t_flag, 1'b1);

    // Done arrives on the same cycle the watchdog would fire: done wins
    t_start = -1; t_dv = -1;
    job_valid_i = 1'b1; job_id_i = 8'h22; job_cfg_i = 32'h5A5A_0022;
    step();
    job_valid_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      core_done_i = (t_start >= 0 && cyc == t_start + 9) ? 4'b0001 : 4'b0000;
      step();
    end
    core_done_i = '0;
    chk("done_latency", 64'(t_dv - t_start), 64'd10);
    chk("done_flag", t_flag, 1'b0);

    // Fill the FIFO with all cores disabled, then flush
    core_en_i = '0; timeout_cycles_i = '0;
    for (int k = 0; k < 9; k++) begin
      job_valid_i = 1'b1; job_id_i = 8'(k + 1); job_cfg_i = $urandom;
      step();
    end
    job_valid_i = 1'b0;
    #1;
    chk("full_ready", job_ready_o, 1'b0);
    chk("full_level", queue_level_o, 4'd8);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    chk("flush_level", queue_level_o, 4'd0);
    chk("flush_start", core_start_o, 4'b0000);
    step();

    // Randomized traffic with a mid-run reset
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0)
        timeout_cycles_i = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 12));
      job_valid_i  = 1'($urandom_range(0, 1));
      job_id_i     = 8'($urandom);
      job_cfg_i    = $urandom;
      flush_i      = ($urandom_range(0, 39) == 0);
      core_en_i    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      core_done_i  = 4'($urandom) & 4'($urandom);
      done_ready_i = ($urandom_range(0, 3) != 0);
      rst_ni       = !(n == 2000 || n == 2001);
      step();
    end
    rst_ni = 1'b1; job_valid_i = 1'b0; flush_i = 1'b0; core_done_i = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
